// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: pipeline WB vs. long-latency aux unit,
// with starvation forcing, global memory freeze and an aux-destination busy scoreboard.
module rf_wb_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wait_mem,
  input  logic            pipe_we,
  input  logic [4:0]      pipe_rd,
  input  logic [XLEN-1:0] pipe_wdata,
  input  logic            aux_issue,
  input  logic [4:0]      aux_issue_rd,
  input  logic            aux_valid,
  input  logic [4:0]      aux_rd,
  input  logic [XLEN-1:0] aux_wdata,
  output logic            aux_ready,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic            issue_rd_busy,
  output logic            pipe_hold,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata
);

  typedef enum logic [1:0] {IDLE, AUX_WAIT, FORCE} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [7:0]  r_wait_cnt;
  logic [7:0]  w_wait_cnt_next;
  logic [7:0]  w_cnt_inc;
  logic [31:0] r_busy;
  logic [31:0] w_busy_next;
  logic        w_pipe_req;
  logic        w_aux_hs;

  assign w_pipe_req = pipe_we && (pipe_rd != 5'd0);
  assign w_aux_hs   = aux_valid && aux_ready;
  assign w_cnt_inc  = r_wait_cnt + 8'd1;

  // Write-port grant: the pipeline has priority unless aux has been starved into FORCE.
  always_comb begin
    aux_ready = 1'b0;
    rf_we     = 1'b0;
    rf_waddr  = 5'd0;
    rf_wdata  = '0;
    if (!rst && !wait_mem) begin
      if (r_state == FORCE) begin
        if (aux_valid) begin
          aux_ready = 1'b1;
          rf_we     = (aux_rd != 5'd0);
          rf_waddr  = aux_rd;
          rf_wdata  = aux_wdata;
        end
      end else if (w_pipe_req) begin
        rf_we    = 1'b1;
        rf_waddr = pipe_rd;
        rf_wdata = pipe_wdata;
      end else if (aux_valid) begin
        aux_ready = 1'b1;
        rf_we     = (aux_rd != 5'd0);
        rf_waddr  = aux_rd;
        rf_wdata  = aux_wdata;
      end
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_wait_cnt_next = r_wait_cnt;
    if (!wait_mem) begin
      case (r_state)
        IDLE, AUX_WAIT: begin
          if (aux_valid && !aux_ready) begin
            w_wait_cnt_next = w_cnt_inc;
            w_state_next    = (w_cnt_inc >= 8'(MAX_WAIT)) ? FORCE : AUX_WAIT;
          end else begin
            w_wait_cnt_next = 8'd0;
            w_state_next    = IDLE;
          end
        end
        default: begin
          w_wait_cnt_next = 8'd0;
          w_state_next    = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_wait_cnt <= 8'd0;
    end else begin
      r_state    <= w_state_next;
      r_wait_cnt <= w_wait_cnt_next;
    end
  end

  // A new issue to the same rd overrides a retiring result: the newer op still owns it.
  assign w_busy_next[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < 32; gi++) begin : g_busy
      assign w_busy_next[gi] =
        (!wait_mem && aux_issue && (aux_issue_rd == 5'(gi))) ? 1'b1 :
        (w_aux_hs && (aux_rd == 5'(gi)))                     ? 1'b0 :
        r_busy[gi];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= 32'd0;
    end else begin
      r_busy <= w_busy_next;
    end
  end

  assign rs1_busy      = r_busy[rs1_addr] && !(w_aux_hs && (aux_rd == rs1_addr));
  assign rs2_busy      = r_busy[rs2_addr] && !(w_aux_hs && (aux_rd == rs2_addr));
  assign issue_rd_busy = r_busy[aux_issue_rd];
  assign pipe_hold     = (r_state == FORCE) && !rst;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed scenarios plus randomized traffic,
// all checked against a cycle-level behavioural model of the write-port rules.
module tb_rf_wb_arbiter;
  localparam int MAX_WAIT = 4;
  localparam int XLEN     = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            wait_mem = 1'b0;
  logic            pipe_we = 1'b0;
  logic [4:0]      pipe_rd = 5'd0;
  logic [XLEN-1:0] pipe_wdata = '0;
  logic            aux_issue = 1'b0;
  logic [4:0]      aux_issue_rd = 5'd0;
  logic            aux_valid = 1'b0;
  logic [4:0]      aux_rd = 5'd0;
  logic [XLEN-1:0] aux_wdata = '0;
  logic            aux_ready;
  logic [4:0]      rs1_addr = 5'd0;
  logic [4:0]      rs2_addr = 5'd0;
  logic            rs1_busy, rs2_busy, issue_rd_busy, pipe_hold, rf_we;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;

  int n_checks = 0;
  int n_errors = 0;

  // Model: set of busy destinations, consecutive denied cycles, forced-slot flag.
  bit [31:0]       m_busy = 32'd0;
  int              m_denied = 0;
  bit              m_forced = 1'b0;
  bit              e_we, e_ready, e_hs, e_hold, e_rs1, e_rs2, e_iss;
  logic [4:0]      e_waddr;
  logic [XLEN-1:0] e_wdata;

  rf_wb_arbiter #(.MAX_WAIT(MAX_WAIT), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .wait_mem(wait_mem),
    .pipe_we(pipe_we), .pipe_rd(pipe_rd), .pipe_wdata(pipe_wdata),
    .aux_issue(aux_issue), .aux_issue_rd(aux_issue_rd),
    .aux_valid(aux_valid), .aux_rd(aux_rd), .aux_wdata(aux_wdata), .aux_ready(aux_ready),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .issue_rd_busy(issue_rd_busy), .pipe_hold(pipe_hold),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic at_neg();
    @(negedge clk);
    if (rst) begin
      m_busy   = 32'd0;
      m_denied = 0;
      m_forced = 1'b0;
    end
    e_hold  = m_forced && !rst;
    e_we    = 1'b0;
    e_ready = 1'b0;
    e_waddr = 5'd0;
    e_wdata = '0;
    if (!rst && !wait_mem) begin
      if (m_forced) begin
        e_ready = aux_valid;
        e_we    = aux_valid && (aux_rd != 5'd0);
        e_waddr = aux_rd;
        e_wdata = aux_wdata;
      end else if (pipe_we && pipe_rd != 5'd0) begin
        e_we    = 1'b1;
        e_waddr = pipe_rd;
        e_wdata = pipe_wdata;
      end else if (aux_valid) begin
        e_ready = 1'b1;
        e_we    = (aux_rd != 5'd0);
        e_waddr = aux_rd;
        e_wdata = aux_wdata;
      end
    end
    e_hs  = aux_valid && e_ready;
    e_rs1 = m_busy[rs1_addr] && !(e_hs && aux_rd == rs1_addr);
    e_rs2 = m_busy[rs2_addr] && !(e_hs && aux_rd == rs2_addr);
    e_iss = m_busy[aux_issue_rd];
    chk("rf_we", 32'(rf_we), 32'(e_we));
    chk("aux_ready", 32'(aux_ready), 32'(e_ready));
    chk("pipe_hold", 32'(pipe_hold), 32'(e_hold));
    chk("rs1_busy", 32'(rs1_busy), 32'(e_rs1));
    chk("rs2_busy", 32'(rs2_busy), 32'(e_rs2));
    chk("issue_rd_busy", 32'(issue_rd_busy), 32'(e_iss));
    if (e_we) begin
      chk("rf_waddr", 32'(rf_waddr), 32'(e_waddr));
      chk("rf_wdata", rf_wdata, e_wdata);
    end
  endtask

  task automatic advance();
    if (!rst && !wait_mem) begin
      if (e_hs) m_busy[aux_rd] = 1'b0;
      if (aux_issue && aux_issue_rd != 5'd0) m_busy[aux_issue_rd] = 1'b1;
      if (m_forced) begin
        m_forced = 1'b0;
        m_denied = 0;
      end else if (aux_valid && !e_hs) begin
        m_denied++;
        if (m_denied >= MAX_WAIT) m_forced = 1'b1;
      end else begin
        m_denied = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wait_mem = 1'b0; pipe_we = 1'b0; pipe_rd = 5'd0; pipe_wdata = '0;
    aux_issue = 1'b0; aux_issue_rd = 5'd0; aux_valid = 1'b0; aux_rd = 5'd0;
    aux_wdata = '0; rs1_addr = 5'd0; rs2_addr = 5'd0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    at_neg();
    advance();
    rst = 1'b0;
  endtask

  initial begin
    idle_inputs();
    at_neg();
    chk("reset_we", 32'(rf_we), 32'd0);
    chk("reset_hold", 32'(pipe_hold), 32'd0);
    advance();
    rst = 1'b0;

    // 1: same-cycle conflict, pipe wins; aux goes next cycle
    pipe_we = 1'b1; pipe_rd = 5'd5; pipe_wdata = 32'h11;
    aux_valid = 1'b1; aux_rd = 5'd7; aux_wdata = 32'h22;
    at_neg();
    chk("t1_waddr_pipe", 32'(rf_waddr), 32'd5);
    chk("t1_ready_low", 32'(aux_ready), 32'd0);
    advance();
    pipe_we = 1'b0;
    at_neg();
    chk("t1_waddr_aux", 32'(rf_waddr), 32'd7);
    chk("t1_wdata_aux", rf_wdata, 32'h22);
    chk("t1_ready_high", 32'(aux_ready), 32'd1);
    advance();
    $display("test1 conflict done");

    // 2: starvation forces an aux slot after MAX_WAIT denials
    do_reset();
    pipe_we = 1'b1; pipe_rd = 5'd3; pipe_wdata = 32'h33;
    aux_valid = 1'b1; aux_rd = 5'd9; aux_wdata = 32'h99;
    for (int i = 0; i < MAX_WAIT; i++) begin
      at_neg();
      chk("t2_denied", 32'(aux_ready), 32'd0);
      advance();
    end
    at_neg();
    chk("t2_force_hold", 32'(pipe_hold), 32'd1);
    chk("t2_force_waddr", 32'(rf_waddr), 32'd9);
    advance();
    aux_valid = 1'b0;
    at_neg();
    chk("t2_after_hold", 32'(pipe_hold), 32'd0);
    chk("t2_after_waddr", 32'(rf_waddr), 32'd3);
    advance();
    $display("test2 force done");

    // 4: freeze in the middle of a denial run keeps the count
    do_reset();
    pipe_we = 1'b1; pipe_rd = 5'd3; pipe_wdata = 32'h44;
    aux_valid = 1'b1; aux_rd = 5'd9; aux_wdata = 32'h55;
    for (int i = 0; i < 2; i++) begin at_neg(); advance(); end
    wait_mem = 1'b1;
    for (int i = 0; i < 3; i++) begin
      at_neg();
      chk("t4_frozen_we", 32'(rf_we), 32'd0);
      chk("t4_frozen_ready", 32'(aux_ready), 32'd0);
      advance();
    end
    wait_mem = 1'b0;
    for (int i = 0; i < MAX_WAIT - 2; i++) begin
      at_neg();
      chk("t4_resume_deny", 32'(aux_ready), 32'd0);
      advance();
    end
    at_neg();
    chk("t4_force_hold", 32'(pipe_hold), 32'd1);
    advance();
    aux_valid = 1'b0;
    at_neg(); advance();
    $display("test4 freeze done");

    // 3: scoreboard set on issue, bypassed on same-cycle handshake
    do_reset();
    aux_issue = 1'b1; aux_issue_rd = 5'd12;
    at_neg(); advance();
    aux_issue = 1'b0; rs1_addr = 5'd12;
    at_neg();
    chk("t3_busy_set", 32'(rs1_busy), 32'd1);
    advance();
    aux_valid = 1'b1; aux_rd = 5'd12; aux_wdata = 32'hC0;
    at_neg();
    chk("t3_busy_bypass", 32'(rs1_busy), 32'd0);
    advance();
    aux_valid = 1'b0;
    at_neg();
    chk("t3_busy_cleared", 32'(rs1_busy), 32'd0);
    advance();
    $display("test3 scoreboard done");

    // 5: rd=0 is ignored; set beats clear on the same rd
    do_reset();
    aux_issue = 1'b1; aux_issue_rd = 5'd0; pipe_we = 1'b1; pipe_rd = 5'd0;
    at_neg();
    chk("t5_rd0_we", 32'(rf_we), 32'd0);
    advance();
    pipe_we = 1'b0;
    at_neg();
    chk("t5_rd0_busy", 32'(issue_rd_busy), 32'd0);
    advance();
    aux_issue_rd = 5'd8;
    at_neg(); advance();
    aux_valid = 1'b1; aux_rd = 5'd8; aux_wdata = 32'h88;
    at_neg();
    chk("t5_waw_flag", 32'(issue_rd_busy), 32'd1);
    advance();
    aux_issue = 1'b0; aux_valid = 1'b0; rs1_addr = 5'd8;
    at_neg();
    chk("t5_set_wins", 32'(rs1_busy), 32'd1);
    advance();
    $display("test5 rd0 and set-wins done");

    // 6: asynchronous reset while in FORCE with a busy destination
    do_reset();
    aux_issue = 1'b1; aux_issue_rd = 5'd4;
    at_neg(); advance();
    aux_issue = 1'b0;
    pipe_we = 1'b1; pipe_rd = 5'd3; pipe_wdata = 32'h66;
    aux_valid = 1'b1; aux_rd = 5'd9; aux_wdata = 32'h77;
    rs1_addr = 5'd4; aux_issue_rd = 5'd4;
    for (int i = 0; i < MAX_WAIT; i++) begin at_neg(); advance(); end
    #1;
    chk("t6_pre_hold", 32'(pipe_hold), 32'd1);
    chk("t6_pre_busy", 32'(rs1_busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("t6_async_hold", 32'(pipe_hold), 32'd0);
    chk("t6_async_we", 32'(rf_we), 32'd0);
    chk("t6_async_ready", 32'(aux_ready), 32'd0);
    chk("t6_async_busy", 32'(rs1_busy), 32'd0);
    chk("t6_async_waw", 32'(issue_rd_busy), 32'd0);
    idle_inputs();
    at_neg(); advance();
    rst = 1'b0;
    $display("test6 async reset done");

    // Randomized traffic; aux_valid/rd/data stay put until accepted
    e_hs = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (!(aux_valid && !e_hs)) begin
        aux_valid = ($urandom_range(0, 2) != 0);
        aux_rd    = 5'($urandom_range(0, 31));
        aux_wdata = $urandom;
      end
      pipe_we      = ($urandom_range(0, 3) != 0);
      pipe_rd      = 5'($urandom_range(0, 31));
      pipe_wdata   = $urandom;
      wait_mem     = ($urandom_range(0, 7) == 0);
      aux_issue    = ($urandom_range(0, 3) == 0);
      aux_issue_rd = 5'($urandom_range(0, 31));
      rs1_addr     = ($urandom_range(0, 1) != 0) ? aux_rd : 5'($urandom_range(0, 31));
      rs2_addr     = 5'($urandom_range(0, 31));
      at_neg();
      advance();
    end
    $display("random traffic done");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
